// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage with a small {pc, instr} FIFO toward decode.
// Owns the fetch PC, stops fetching after the halt word 16'hFFFF, and flushes on redirect.
// Optional build macro FETCHQ_BYPASS_EN: when the queue is empty, the word being
// fetched is presented on the output in the same cycle (zero-latency bypass).
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [15:0]              imem_addr,
  input  logic [15:0]              imem_data,
  input  logic                     redirect,
  input  logic [15:0]              redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_instr,
  output logic [15:0]              out_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);

  localparam int          PW        = $clog2(DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  logic [15:0]   fpc;
  logic          fetch_stop;
  logic          halted_r;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [15:0]   mem_pc    [DEPTH];
  logic [15:0]   mem_instr [DEPTH];

  logic head_vld;
  logic byp;
  logic fetch;
  logic deq;
  logic push;
  logic pop;
  logic halt_deq;

  // Handshake, fetch decision and head/bypass output selection
  always_comb begin
    head_vld = (cnt != '0);
    // A full queue can still fetch when the head leaves this cycle; redirect is
    // already excluded here, so out_ready && head_vld is the dequeue condition.
    fetch    = !fetch_stop && !redirect &&
               ((cnt < CW'(DEPTH)) || (out_ready && head_vld));
`ifdef FETCHQ_BYPASS_EN
    byp      = !reset && !fetch_stop && !redirect && (cnt == '0);
`else
    byp      = 1'b0;
`endif
    out_valid = (head_vld && !redirect) || byp;
    if (byp) begin
      out_instr = imem_data;
      out_pc    = fpc;
    end else if (head_vld) begin
      out_instr = mem_instr[rd_ptr];
      out_pc    = mem_pc[rd_ptr];
    end else begin
      out_instr = '0;
      out_pc    = '0;
    end
    deq      = out_valid && out_ready;
    pop      = deq && head_vld;
    // A bypassed word that the consumer takes immediately never enters the FIFO
    push     = fetch && !(byp && out_ready);
    halt_deq = deq && (out_instr == HALT_WORD);
  end

  // Control state: fetch PC, pointers, occupancy, halt tracking; redirect outranks all but reset
  always_ff @(posedge clock) begin
    if (reset) begin
      fpc        <= RESET_PC;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      fetch_stop <= 1'b0;
      halted_r   <= 1'b0;
    end else if (redirect) begin
      fpc        <= {redirect_pc[15:1], 1'b0};
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      fetch_stop <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      if (fetch) begin
        fpc <= fpc + 16'd2;
        if (imem_data == HALT_WORD) fetch_stop <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (halt_deq) halted_r <= 1'b1;
    end
  end

  // FIFO storage: data only, no reset needed since reads are gated by occupancy
  always_ff @(posedge clock) begin
    if (push) begin
      mem_pc[wr_ptr]    <= fpc;
      mem_instr[wr_ptr] <= imem_data;
    end
  end

  assign imem_addr = fpc;
  assign count     = cnt;
  assign halted    = halted_r;

endmodule
